// File: rtl/aclk_ctrl_pkg.sv
// Shared types and BCD digit limits for the aclock keypad configuration sequencer.
package aclk_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ENTER, LOAD} set_state_t;
  typedef enum logic {TGT_TIME, TGT_ALARM} set_target_t;

  localparam logic [3:0] H1_MAX    = 4'd2;
  localparam logic [3:0] H0_MAX_H2 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] DIG_MAX   = 4'd9;

endpackage

// File: rtl/aclk_digit_check.sv
// Combinational 24-hour HH:MM validity check for one keypad digit at a given position.
module aclk_digit_check
  import aclk_ctrl_pkg::*;
(
  input  logic [1:0] digit_idx,
  input  logic [3:0] key_digit,
  input  logic [1:0] h1,
  output logic       valid
);

  always_comb begin
    valid = 1'b0;
    if (key_digit <= DIG_MAX) begin
      case (digit_idx)
        2'd0:    valid = (key_digit <= H1_MAX);
        // Hours 20..23 only: the unit digit is capped once the tens digit is 2.
        2'd1:    valid = (h1 == 2'd2) ? (key_digit <= H0_MAX_H2) : 1'b1;
        2'd2:    valid = (key_digit <= M1_MAX);
        default: valid = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/aclk_set_ctrl.sv
// Keypad entry sequencer: collects HH:MM digits and issues one LD_time/LD_alarm pulse.
// Optional idle-entry abort is built when ACLK_SET_TIMEOUT_EN is defined.
module aclk_set_ctrl
  import aclk_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       cancel,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       busy,
  output logic [1:0] digit_idx,
  output logic       err,
  output logic       timeout
);

  set_state_t  state, state_d;
  set_target_t target, target_d;
  logic [1:0]  h1_d, idx_d;
  logic [3:0]  h0_d, m1_d, m0_d;
  logic        digit_ok, err_d, to_d;

  aclk_digit_check u_check (
    .digit_idx (digit_idx),
    .key_digit (key_digit),
    .h1        (H_in1),
    .valid     (digit_ok)
  );

`ifdef ACLK_SET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d  = state;
    target_d = target;
    idx_d    = digit_idx;
    h1_d     = H_in1;
    h0_d     = H_in0;
    m1_d     = M_in1;
    m0_d     = M_in0;
    err_d    = 1'b0;
    to_d     = 1'b0;
`ifdef ACLK_SET_TIMEOUT_EN
    cnt_d    = '0;
`endif
    case (state)
      IDLE: begin
        if (set_time || set_alarm) begin
          state_d  = ENTER;
          target_d = set_time ? TGT_TIME : TGT_ALARM;
          idx_d    = 2'd0;
        end
      end
      ENTER: begin
        if (cancel) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (key_valid) begin
          if (digit_ok) begin
            case (digit_idx)
              2'd0:    h1_d = key_digit[1:0];
              2'd1:    h0_d = key_digit;
              2'd2:    m1_d = key_digit;
              default: m0_d = key_digit;
            endcase
            // Wraps 3 -> 0, leaving the index cleared for the next entry.
            idx_d = digit_idx + 2'd1;
            if (digit_idx == 2'd3) state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
`ifdef ACLK_SET_TIMEOUT_EN
        end else if (cnt == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = IDLE;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt + 1'b1;
`endif
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a register fed from the next-state decode above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      target    <= TGT_TIME;
      digit_idx <= 2'd0;
      H_in1     <= 2'd0;
      H_in0     <= 4'd0;
      M_in1     <= 4'd0;
      M_in0     <= 4'd0;
      LD_time   <= 1'b0;
      LD_alarm  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      target    <= target_d;
      digit_idx <= idx_d;
      H_in1     <= h1_d;
      H_in0     <= h0_d;
      M_in1     <= m1_d;
      M_in0     <= m0_d;
      LD_time   <= (state_d == LOAD) && (target_d == TGT_TIME);
      LD_alarm  <= (state_d == LOAD) && (target_d == TGT_ALARM);
      busy      <= (state_d != IDLE);
      err       <= err_d;
    end
  end

`ifdef ACLK_SET_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      timeout <= to_d;
    end
  end
`else
  logic unused_to;
  assign unused_to = to_d;
  assign timeout   = 1'b0;
`endif

endmodule

// File: doc/aclk_set_ctrl.md
# aclk_set_ctrl

Keypad-driven configuration sequencer for the `aclock` core. It collects four BCD digits from a single-digit keypad interface, validates each against 24-hour HH:MM limits, and holds them on the core's `H_in1/H_in0/M_in1/M_in0` inputs. When the fourth digit is accepted, it issues exactly one `LD_time` or `LD_alarm` pulse. It sits between the user-input front end and `aclock`, and is the only driver of the core's load-side inputs.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1000: idle cycles in entry before abort. Used only with `ACLK_SET_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `set_time`  in  1  level; starts time entry when sampled high in IDLE.
- `set_alarm`  in  1  level; starts alarm entry when sampled high in IDLE.
- `cancel`  in  1  aborts entry, with no load.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  4  BCD digit entered.
- `H_in1`  out  2  hour tens, to `aclock`.
- `H_in0`  out  4  hour units.
- `M_in1`  out  4  minute tens.
- `M_in0`  out  4  minute units.
- `LD_time`  out  1  one-cycle load-time pulse.
- `LD_alarm`  out  1  one-cycle load-alarm pulse.
- `busy`  out  1  high in ENTER and LOAD.
- `digit_idx`  out  2  next digit position: 0=H1, 1=H0, 2=M1, 3=M0.
- `err`  out  1  one-cycle pulse when a digit is rejected.
- `timeout`  out  1  one-cycle pulse when entry is aborted by timeout.

## Operation
- States: IDLE, ENTER, LOAD. A `target` register (TIME/ALARM) is latched when entry starts.
- **IDLE**
  - `set_time` → ENTER, target=TIME.
  - Otherwise `set_alarm` → ENTER, target=ALARM.
  - If both are high, `set_time` wins.
  - `digit_idx` is cleared to 0 on entry.
  - `key_valid` and `cancel` are ignored.
- **ENTER**
  - `cancel` has priority over `key_valid` in the same cycle: → IDLE, no LD pulse. Digit registers keep their partial values, which is harmless because no load is issued.
  - `key_valid` with a valid digit: the digit is written into the register at position `digit_idx`, and `digit_idx` increments. If `digit_idx` was 3 → LOAD.
  - `key_valid` with an invalid digit: `err` pulses, the register and `digit_idx` are unchanged.
  - `set_time` and `set_alarm` are ignored.
- **Validity rules**
  - `key_digit` > 9 is always invalid.
  - Position 0: ≤ 2.
  - Position 1: ≤ 3 if the stored H1 is 2, else ≤ 9.
  - Position 2: ≤ 5.
  - Position 3: ≤ 9.
  - H_in1 is stored as the low 2 bits of the digit.
- **LOAD**: lasts exactly one cycle. `LD_time` (target TIME) or `LD_alarm` (target ALARM) is high, then → IDLE unconditionally. `cancel` is ignored in LOAD.
- **Reset** (in any state): → IDLE. All outputs and digit registers are 0, `target` = TIME. A reset during ENTER produces no LD pulse.

## Timing
- All outputs are registered.
- A start input sampled at edge E: `busy` = 1 from E.
- A key accepted at edge K: the digit output and `digit_idx` update at K.
- The fourth digit accepted at edge K:
  - The LD pulse is high for the cycle K..K+1.
  - `H_in*/M_in*` already hold the final values during that cycle.
  - At K+1: `busy` = 0 and the state is IDLE.
- Load latency from the last key strobe: 1 cycle.
- `err` and `timeout` are high for exactly one cycle, starting at the edge of the event.
- `digit_idx` holds 0 after LOAD, cancel, and timeout.

## Configuration
- `ACLK_SET_TIMEOUT_EN` defined:
  - A counter clears on entry to ENTER and on every `key_valid` (accepted or rejected).
  - When the counter reaches `TIMEOUT_CYC-1` in ENTER with no key: `timeout` pulses, → IDLE, no LD pulse.
  - `cancel` and `key_valid` in that same cycle take priority over the timeout.
- Not defined: no counter is built, and `timeout` is tied to 0.

## Structure
- Shared package `aclk_ctrl_pkg` holds:
  - `typedef enum {IDLE, ENTER, LOAD} set_state_t`.
  - `typedef enum {TGT_TIME, TGT_ALARM} set_target_t`.
  - Digit limit constants `H1_MAX=2`, `H0_MAX_H2=3`, `M1_MAX=5`, `DIG_MAX=9`.
- One sub-module: `aclk_digit_check`, combinational. Inputs are `digit_idx`, `key_digit` and the stored H1; output is `valid`. Verification can reuse it as a reference model.

## Test plan
- **Reset**: assert `reset` for 2 cycles → all outputs 0, `busy`=0, `digit_idx`=0.
- **Time entry**: pulse `set_time`, then keys 1,2,3,4 → `H_in1`=1, `H_in0`=2, `M_in1`=3, `M_in0`=4. `LD_time` is high for exactly 1 cycle, in the cycle after the key-4 edge; `LD_alarm` stays 0; `busy` falls the next edge.
- **Alarm entry with rejection**: pulse `set_alarm`, then keys 2,4 → `err` pulse on 4 and `digit_idx` stays 1. Then keys 3,5,9 → alarm 23:59 with a single `LD_alarm` pulse. Key 6 at position 2, and key 10 at any position, → `err`.
- **Cancel**: `set_time`, keys 1,5, then `cancel` together with `key_valid`=1 → no LD pulse, IDLE, `digit_idx`=0, digit not stored.
- **Priority and abort**:
  - `set_time` and `set_alarm` high together → target TIME.
  - `reset` asserted after 3 digits → no LD pulse, all outputs 0.
- **Timeout** (with `ACLK_SET_TIMEOUT_EN`, `TIMEOUT_CYC`=16): `set_alarm`, key 1, then 16 idle cycles → `timeout` pulse, IDLE, no `LD_alarm`. A key on cycle 15 restarts the count.
